serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-direction arithmetic block to the team's combinational ripple full adder. It is intended for area-constrained datapaths on the Cyclone IV, where latency can be traded for logic. A start/done handshake sequences each operation, and results hold stable until the next accepted start.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The master drives start and the operands; the slave returns status and results.
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_ZERO_FLAG_EN to compile in the zero-detect flag; otherwise zero is tied to 0.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; previous results held
    // RUN   | one bit per edge through the full-subtractor cell
    // DONE  | one-cycle done pulse; results valid
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-2:0]  res_sr;
    logic          bin;
    logic          a_msb;
    logic          b_msb;
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  diff_r;
    logic          borrow_r;
    logic          ovf_r;

    logic          a_bit;
    logic          b_bit;
    logic          d_bit;
    logic          bout;
    logic [N-1:0]  res_next;
    logic          last_bit;

    always_comb begin
        a_bit    = a_sr[0];
        b_bit    = b_sr[0];
        d_bit    = a_bit ^ b_bit ^ bin;
        bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
        res_next = {d_bit, res_sr};
        last_bit = (state == RUN) && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bin      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        a_msb  <= bus.a[N-1];
                        b_msb  <= bus.b[N-1];
                        bin    <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // The result fills from the MSB side, so bit 0 lands at the bottom after N shifts.
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next[N-1:1];
                    bin    <= bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= DONE;
                        done_r   <= 1'b1;
                        diff_r   <= res_next;
                        borrow_r <= bout;
                        ovf_r    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_r <= 1'b0;
        end else if (last_bit) begin
            zero_r <= (res_next == '0);
        end
    end

    assign bus.zero = zero_r;
`else
    assign bus.zero = 1'b0;
`endif

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.diff   = diff_r;
    assign bus.borrow = borrow_r;
    assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, handshake corner cases,
// and random operands checked against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int N = 8;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.N(N)) sif ();

    serial_subtractor #(.N(N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular/unsigned/signed arithmetic on the whole words.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] d, output logic brw, output logic ov);
        int ua, ub, sa, sb, sd;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        sd  = sa - sb;
        d   = N'(ua - ub);
        brw = (ua < ub);
        ov  = (sd > (2 ** (N - 1)) - 1) || (sd < -(2 ** (N - 1)));
    endfunction

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (sif.done) got = 1'b1;
        end
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] d, output logic brw, output logic ov,
                          output logic z);
        int c0, busy_n;
        bit got;
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = a;
        sif.b     = b;
        @(posedge clk);
        #1;
        c0        = cyc;
        sif.start = 1'b0;
        sif.a     = N'($urandom);
        sif.b     = N'($urandom);
        busy_n    = 0;
        got       = 1'b0;
        for (int k = 0; k <= N + 4 && !got; k++) begin
            @(negedge clk);
            if (sif.busy) busy_n++;
            if (sif.done) got = 1'b1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", 32'(cyc - c0), 32'(N));
        d   = sif.diff;
        brw = sif.borrow;
        ov  = sif.ovf;
        z   = sif.zero;
        @(negedge clk);
        if (!sif.busy) busy_n = busy_n + 0;
        check("done_width", 32'(sif.done), 32'd0);
        check("busy_fall", 32'(sif.busy), 32'd0);
        check("busy_cycles", 32'(busy_n), 32'(N + 1));
        check("hold_diff", 32'(sif.diff), 32'(d));
    endtask

    initial begin
        logic [N-1:0] d, ed;
        logic         brw, ov, z, ebrw, eov;
        bit           got;
        int           n_done;
        int           dq[$];

        vecs[0] = '{a: 8'd100, b: 8'd58,  diff: 8'h2A, borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'd3,   b: 8'd5,   diff: 8'hFE, borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h7F,  b: 8'hFF,  diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'h55,  b: 8'h55,  diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'hFF,  b: 8'h00,  diff: 8'hFF, borrow: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h00,  b: 8'h80,  diff: 8'h80, borrow: 1'b1, ovf: 1'b1};

        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        #12;
        check("rst_busy", 32'(sif.busy), 32'd0);
        check("rst_done", 32'(sif.done), 32'd0);
        check("rst_diff", 32'(sif.diff), 32'd0);
        check("rst_flags", {29'd0, sif.borrow, sif.ovf, sif.zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, d, brw, ov, z);
            check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].diff));
            check($sformatf("vec%0d_borrow", i), 32'(brw), 32'(vecs[i].borrow));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(ZEN && (vecs[i].diff == 0)));
        end

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 8'h10;
        sif.b     = 8'h03;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        begin
            int c0;
            c0 = cyc;
            repeat (3) @(negedge clk);
            sif.start = 1'b1;
            sif.a     = 8'h99;
            sif.b     = 8'h11;
            @(negedge clk);
            sif.start = 1'b0;
            wait_done(N + 4, got);
            check("ign_done_seen", 32'(got), 32'd1);
            check("ign_latency", 32'(cyc - c0), 32'(N));
            check("ign_diff", 32'(sif.diff), 32'h0D);
        end
        n_done = 0;
        repeat (2 * N) begin
            @(negedge clk);
            if (sif.done) n_done++;
        end
        check("ign_no_second_done", 32'(n_done), 32'd0);
        check("ign_idle", 32'(sif.busy), 32'd0);

        // start held high: completions every N+2 cycles
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 8'd9;
        sif.b     = 8'd4;
        repeat (4 * (N + 2) + 4) begin
            @(negedge clk);
            if (sif.done) dq.push_back(cyc);
        end
        sif.start = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("held_completions", 32'(dq.size() >= 3), 32'd1);
        for (int i = 1; i < dq.size(); i++)
            check($sformatf("held_spacing%0d", i), 32'(dq[i] - dq[i-1]), 32'(N + 2));
        check("held_diff", 32'(sif.diff), 32'd5);

        // async reset on the 4th RUN cycle, with nonzero results already on the outputs
        run_op(8'h7F, 8'hFF, d, brw, ov, z);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 8'hF0;
        sif.b     = 8'h0F;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(sif.busy), 32'd0);
        check("arst_done", 32'(sif.done), 32'd0);
        check("arst_diff", 32'(sif.diff), 32'd0);
        check("arst_flags", {29'd0, sif.borrow, sif.ovf, sif.zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (sif.done || sif.busy) n_done++;
        end
        check("arst_discarded", 32'(n_done), 32'd0);
        run_op(8'hF0, 8'h0F, d, brw, ov, z);
        check("arst_redo_diff", 32'(d), 32'hE1);
        check("arst_redo_borrow", 32'(brw), 32'd0);
        check("arst_redo_ovf", 32'(ov), 32'd0);

        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = N'($urandom);
            if (i % 10 == 0) rb = ra;
            model(ra, rb, ed, ebrw, eov);
            run_op(ra, rb, d, brw, ov, z);
            check($sformatf("rnd%0d_diff a=%0h b=%0h", i, ra, rb), 32'(d), 32'(ed));
            check($sformatf("rnd%0d_borrow", i), 32'(brw), 32'(ebrw));
            check($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
            check($sformatf("rnd%0d_zero", i), 32'(z), 32'(ZEN && (ed == 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
